// File: rtl/timing_pkg.sv
// Shared timing definitions: timing-hub and phase-compute scheduler state
// encodings, duty width and phase codes.
package timing_pkg;

   localparam int DUTY_W     = 12;
   localparam int NUM_PHASES = 3;

   typedef enum logic [2:0] {
      HUB_RESET  = 3'd0,
      HUB_ALIGN  = 3'd1,
      HUB_RUN    = 3'd2,
      HUB_FAULT  = 3'd3
   } hub_state_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      PEND  = 3'd3,
      ABORT = 3'd4
   } sched_state_t;

   typedef enum logic [1:0] {
      PH_A = 2'd0,
      PH_B = 2'd1,
      PH_C = 2'd2
   } phase_t;

endpackage

// File: rtl/budget_timer.sv
// Saturating tick counter that flags when the compute budget limit is reached
// while the counted activity is running.
module budget_timer #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         run,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (run && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = run && (count_q == limit);

endmodule

// File: rtl/phase_compute_sched.sv
// Phase compute scheduler: runs three shared-engine duty computations per PWM
// period under a tick budget and commits them together at the PWM wrap.
module phase_compute_sched #(
   parameter int PWM_TICKS      = 4096,
   parameter int COMPUTE_BUDGET = 416,
   parameter int DUTY_W         = timing_pkg::DUTY_W
) (
   input  logic              clk_ctrl,
   input  logic              rst_ctrl,
   input  logic              compute_trig,
   input  logic [11:0]       pwm_ctr,
   input  logic              fault,
   output logic              eng_start,
   output logic [1:0]        eng_phase,
   input  logic              eng_done,
   input  logic [DUTY_W-1:0] eng_duty,
   output logic [DUTY_W-1:0] duty_a,
   output logic [DUTY_W-1:0] duty_b,
   output logic [DUTY_W-1:0] duty_c,
   output logic              commit,
   output logic              overrun,
   output logic              busy,
   output logic [2:0]        sched_state
);

   import timing_pkg::*;

   localparam int                    BUDGET_W     = $clog2(COMPUTE_BUDGET + 1);
   localparam logic [BUDGET_W-1:0]   BUDGET_LIMIT = BUDGET_W'(COMPUTE_BUDGET - 1);
   localparam logic [11:0]           PWM_WRAP     = 12'(PWM_TICKS - 1);

   sched_state_t state_q, state_d;
   logic [1:0]   phase_q, phase_d;
   logic [2:0][DUTY_W-1:0] shadow_q, shadow_d;
   logic [2:0][DUTY_W-1:0] duty_q, duty_d;
   logic         eng_start_q, eng_start_d;
   logic         commit_q, commit_d;
   logic         overrun_q, overrun_d;
   logic         busy_q, busy_d;

   logic         start_seq;
   logic         timer_run;
   logic         budget_expired;
   logic         final_done;

   assign start_seq = (state_q == IDLE) && compute_trig && !fault;
   assign timer_run = (state_q == ISSUE) || (state_q == WAIT);

   budget_timer #(
      .W(BUDGET_W)
   ) u_budget_timer (
      .clk     (clk_ctrl),
      .rst     (rst_ctrl),
      .clear   (start_seq),
      .run     (timer_run),
      .limit   (BUDGET_LIMIT),
      .expired (budget_expired)
   );

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      shadow_d   = shadow_q;
      duty_d     = duty_q;
      commit_d   = 1'b0;
      overrun_d  = 1'b0;
      final_done = (state_q == WAIT) && eng_done && (phase_q == PH_C);

      if (compute_trig && !fault && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start_seq) begin
               phase_d = PH_A;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (eng_done) begin
               for (int p = 0; p < NUM_PHASES; p++) begin
                  if (phase_q == 2'(p)) shadow_d[p] = eng_duty;
               end
               if (phase_q == PH_C) begin
                  state_d = PEND;
               end else begin
                  phase_d = phase_q + 2'd1;
                  state_d = ISSUE;
               end
            end
         end
         PEND: begin
            if (pwm_ctr == PWM_WRAP) begin
               duty_d   = shadow_q;
               commit_d = 1'b1;
               state_d  = IDLE;
            end
         end
         ABORT: begin
            shadow_d = '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A final result landing on the last budget tick still counts as success.
      if (budget_expired && !final_done) begin
         overrun_d = 1'b1;
         state_d   = ABORT;
      end

      if (fault) begin
         state_d   = IDLE;
         duty_d    = '0;
         commit_d  = 1'b0;
         overrun_d = 1'b0;
      end
   end

   // Outputs are registered from the next state so they line up with sched_state.
   assign eng_start_d = (state_d == ISSUE);
   assign busy_d      = (state_d != IDLE);

   // NOTE: shadows and duties are a handful of flops, so they take the async
   // reset like everything else; a mid-sequence reset discards partial results.
   always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
      if (rst_ctrl) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         shadow_q    <= '0;
         duty_q      <= '0;
         eng_start_q <= 1'b0;
         commit_q    <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         shadow_q    <= shadow_d;
         duty_q      <= duty_d;
         eng_start_q <= eng_start_d;
         commit_q    <= commit_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign eng_start   = eng_start_q;
   assign eng_phase   = phase_q;
   assign duty_a      = duty_q[0];
   assign duty_b      = duty_q[1];
   assign duty_c      = duty_q[2];
   assign commit      = commit_q;
   assign overrun     = overrun_q;
   assign busy        = busy_q;
   assign sched_state = state_q;

endmodule

// File: tb/tb_phase_compute_sched.sv
// Self-checking bench for phase_compute_sched: directed and random sequences
// checked against a timeline model of engine latencies, budget and PWM wrap.
module tb_phase_compute_sched;

   localparam int B    = 416;
   localparam int MAXO = 4700;

   logic        clk_ctrl     = 1'b0;
   logic        rst_ctrl     = 1'b1;
   logic        compute_trig = 1'b0;
   logic [11:0] pwm_ctr      = 12'd0;
   logic        fault        = 1'b0;
   logic        eng_done     = 1'b0;
   logic [11:0] eng_duty     = 12'd0;
   logic        eng_start;
   logic [1:0]  eng_phase;
   logic [11:0] duty_a, duty_b, duty_c;
   logic        commit, overrun, busy;
   logic [2:0]  sched_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [35:0] exp_duty = 36'd0;

   logic [2:0]  tr_state   [MAXO];
   logic        tr_start   [MAXO];
   logic [1:0]  tr_phase   [MAXO];
   logic        tr_commit  [MAXO];
   logic        tr_overrun [MAXO];
   logic        tr_busy    [MAXO];
   logic [35:0] tr_duty    [MAXO];

   phase_compute_sched dut (
      .clk_ctrl     (clk_ctrl),
      .rst_ctrl     (rst_ctrl),
      .compute_trig (compute_trig),
      .pwm_ctr      (pwm_ctr),
      .fault        (fault),
      .eng_start    (eng_start),
      .eng_phase    (eng_phase),
      .eng_done     (eng_done),
      .eng_duty     (eng_duty),
      .duty_a       (duty_a),
      .duty_b       (duty_b),
      .duty_c       (duty_c),
      .commit       (commit),
      .overrun      (overrun),
      .busy         (busy),
      .sched_state  (sched_state)
   );

   always #5 clk_ctrl = ~clk_ctrl;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs set before tick() are sampled at its rising edge; returns at the
   // following falling edge with outputs settled.
   task automatic tick();
      @(posedge clk_ctrl);
      @(negedge clk_ctrl);
      pwm_ctr = pwm_ctr + 12'd1;
   endtask

   task automatic record(input int o);
      tr_state[o]   = sched_state;
      tr_start[o]   = eng_start;
      tr_phase[o]   = eng_phase;
      tr_commit[o]  = commit;
      tr_overrun[o] = overrun;
      tr_busy[o]    = busy;
      tr_duty[o]    = {duty_a, duty_b, duty_c};
   endtask

   // Trigger at offset 0, then act as the engine: answer each eng_start after
   // lat[phase] edges (lat 0 = never answer). Trace index = edges after trigger.
   task automatic run_seq(input int pwm0, input int l0, input int l1, input int l2,
                          input logic [11:0] v0, input logic [11:0] v1, input logic [11:0] v2,
                          input int n_edges, input int trig2_off, input int fault_off,
                          input int late_off);
      int          lat [3];
      logic [11:0] val [3];
      bit          pend;
      int          done_o;
      int          ph;
      logic [11:0] pend_val;
      lat[0] = l0; lat[1] = l1; lat[2] = l2;
      val[0] = v0; val[1] = v1; val[2] = v2;
      pend = 1'b0; done_o = 0; pend_val = 12'd0;
      pwm_ctr = 12'(pwm0);
      compute_trig = 1'b1;
      tick();
      compute_trig = 1'b0;
      record(0);
      for (int o = 1; o < n_edges; o++) begin
         ph = int'(tr_phase[o-1]);
         if (tr_start[o-1] && ph < 3 && lat[ph] != 0) begin
            pend     = 1'b1;
            done_o   = o - 1 + lat[ph];
            pend_val = val[ph];
         end
         compute_trig = (o == trig2_off);
         fault        = (fault_off >= 0) && (o >= fault_off) && (o < fault_off + 3);
         eng_done     = 1'b0;
         eng_duty     = 12'd0;
         if (pend && done_o == o) begin
            eng_done = 1'b1;
            eng_duty = pend_val;
            pend     = 1'b0;
         end
         if (o == late_off) begin
            eng_done = 1'b1;
            eng_duty = 12'h3E7;
         end
         tick();
         record(o);
      end
      compute_trig = 1'b0;
      fault        = 1'b0;
      eng_done     = 1'b0;
      eng_duty     = 12'd0;
   endtask

   // Timeline model: phase i starts when phase i-1 finishes; intermediate results
   // must land before tick B, the final one no later than B; commit follows at
   // the first edge after the final result where pwm_ctr reads 4095.
   task automatic seq_test(input string tag, input int pwm0,
                           input int l0, input int l1, input int l2,
                           input logic [11:0] v0, input logic [11:0] v1, input logic [11:0] v2,
                           input int trig2_off, input int late_off);
      int lat [3];
      int s [3];
      int d [3];
      int n_st, t, ov_edge, cm_edge, n_edges, n_ov_exp;
      int cnt_st, cnt_ov, cnt_cm;
      bit ok;
      lat[0] = l0; lat[1] = l1; lat[2] = l2;
      s = '{0, 0, 0}; d = '{0, 0, 0};
      n_st = 0; t = 0; ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (ok) begin
            s[i] = t;
            n_st++;
            d[i] = t + lat[i];
            if (lat[i] == 0) ok = 1'b0;
            else if (d[i] < B || (i == 2 && d[i] == B)) t = d[i];
            else ok = 1'b0;
         end
      end
      ov_edge = ok ? -1 : B;
      cm_edge = ok ? d[2] + 1 + (4095 - ((pwm0 + d[2] + 1) % 4096)) : -1;
      n_edges = ok ? cm_edge + 4 : ((late_off > B) ? late_off + 4 : B + 4);
      if (n_edges > MAXO) n_edges = MAXO;
      n_ov_exp = (ov_edge >= 0 ? 1 : 0) + (trig2_off >= 0 ? 1 : 0);

      run_seq(pwm0, l0, l1, l2, v0, v1, v2, n_edges, trig2_off, -1, late_off);

      cnt_st = 0; cnt_ov = 0; cnt_cm = 0;
      for (int o = 0; o < n_edges; o++) begin
         cnt_st += int'(tr_start[o]);
         cnt_ov += int'(tr_overrun[o]);
         cnt_cm += int'(tr_commit[o]);
      end
      check($sformatf("%s/start_count", tag), cnt_st, n_st);
      for (int i = 0; i < n_st; i++) begin
         check($sformatf("%s/start%0d", tag, i), tr_start[s[i]], 1);
         check($sformatf("%s/phase%0d", tag, i), tr_phase[s[i]], i);
      end
      check($sformatf("%s/overrun_count", tag), cnt_ov, n_ov_exp);
      if (trig2_off >= 0) check($sformatf("%s/trig_drop_overrun", tag), tr_overrun[trig2_off], 1);
      check($sformatf("%s/commit_count", tag), cnt_cm, ok ? 1 : 0);
      if (ok) begin
         check($sformatf("%s/pend_state", tag), tr_state[d[2]], 3);
         check($sformatf("%s/pend_busy", tag), tr_busy[d[2]], 1);
         check($sformatf("%s/commit", tag), tr_commit[cm_edge], 1);
         check($sformatf("%s/commit_duty", tag), tr_duty[cm_edge], {v0, v1, v2});
         check($sformatf("%s/commit_idle", tag), tr_state[cm_edge], 0);
         exp_duty = {v0, v1, v2};
      end else begin
         check($sformatf("%s/budget_overrun", tag), tr_overrun[B], 1);
         check($sformatf("%s/abort_state", tag), tr_state[B], 4);
         check($sformatf("%s/abort_to_idle", tag), tr_state[B+1], 0);
         check($sformatf("%s/duty_kept", tag), tr_duty[n_edges-1], exp_duty);
      end
      check($sformatf("%s/end_state", tag), tr_state[n_edges-1], 0);
      check($sformatf("%s/end_busy", tag), tr_busy[n_edges-1], 0);
      repeat (5) tick();
   endtask

   initial begin
      int cnt_cm;
      int cnt_st;

      // Reset state
      repeat (3) @(negedge clk_ctrl);
      check("reset/duties", {duty_a, duty_b, duty_c}, 0);
      check("reset/state", sched_state, 0);
      check("reset/busy", busy, 0);
      check("reset/pulses", {eng_start, commit, overrun}, 0);
      check("reset/eng_phase", eng_phase, 0);
      rst_ctrl = 1'b0;
      tick();

      // Trigger while fault is high is ignored without overrun
      fault = 1'b1;
      compute_trig = 1'b1;
      tick();
      compute_trig = 1'b0;
      fault = 1'b0;
      check("fault_trig/state", sched_state, 0);
      check("fault_trig/overrun", overrun, 0);
      tick();

      // Nominal: three phases, 20 cycles each, commit at the wrap
      seq_test("nominal", 3600, 20, 20, 20, 12'd100, 12'd200, 12'd300, -1, -1);

      // Engine stalls on phase B; late done during ABORT is ignored
      seq_test("stall_b", 3600, 20, 0, 20, 12'd11, 12'd22, 12'd33, -1, B + 1);

      // Final result exactly on the last budget tick is a success
      seq_test("edge_budget", 3600, 20, 20, B - 40, 12'd7, 12'd8, 12'd9, -1, -1);

      // Second trigger during WAIT is dropped with an overrun pulse
      seq_test("trig_in_wait", 3600, 20, 20, 20, 12'h111, 12'h222, 12'h333, 10, -1);

      // Fault during PEND: duties zeroed next cycle, no commit at wrap
      run_seq(3600, 20, 20, 20, 12'd500, 12'd600, 12'd700, 500, -1, 100, -1);
      check("fault_pend/state_before", tr_state[99], 3);
      check("fault_pend/duty_before", tr_duty[99], exp_duty);
      check("fault_pend/duty_zero", tr_duty[100], 0);
      check("fault_pend/state_idle", tr_state[100], 0);
      cnt_cm = 0;
      for (int o = 0; o < 500; o++) cnt_cm += int'(tr_commit[o]);
      check("fault_pend/no_commit", cnt_cm, 0);
      check("fault_pend/wrap_idle", tr_state[495], 0);
      exp_duty = 36'd0;
      repeat (5) tick();

      // Random latencies, values and PWM phase; some runs exceed the budget
      for (int r = 0; r < 6; r++) begin
         seq_test($sformatf("rand%0d", r), int'($urandom_range(0, 4095)),
                  int'($urandom_range(2, 200)), int'($urandom_range(2, 200)),
                  int'($urandom_range(2, 200)),
                  12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                  12'($urandom_range(0, 4095)), -1, -1);
      end

      seq_test("preload", 4000, 10, 10, 10, 12'hABC, 12'h123, 12'h456, -1, -1);

      // Asynchronous reset mid-WAIT on phase B
      pwm_ctr = 12'd100;
      compute_trig = 1'b1;
      tick();
      compute_trig = 1'b0;
      tick();
      tick();
      eng_done = 1'b1;
      eng_duty = 12'h777;
      tick();
      eng_done = 1'b0;
      eng_duty = 12'd0;
      tick();
      tick();
      check("rst_mid/state_wait", sched_state, 2);
      check("rst_mid/phase_b", eng_phase, 1);
      check("rst_mid/duty_before", {duty_a, duty_b, duty_c}, exp_duty);
      #2 rst_ctrl = 1'b1;
      #1;
      check("rst_async/duties", {duty_a, duty_b, duty_c}, 0);
      check("rst_async/state_busy", {sched_state, busy}, 0);
      check("rst_async/phase", eng_phase, 0);
      @(negedge clk_ctrl);
      rst_ctrl = 1'b0;
      exp_duty = 36'd0;
      cnt_st = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         cnt_st += int'(eng_start);
      end
      check("rst_after/no_start", cnt_st, 0);
      check("rst_after/idle", sched_state, 0);

      seq_test("recover", int'($urandom_range(0, 4095)), 15, 25, 35,
               12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
               12'($urandom_range(0, 4095)), -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
